// File: rtl/pistorm_bus_engine.sv
`timescale 1ns/1ps
// Queued 68000 bus-cycle engine clocked by PI_CLK. M68K_CLK and the bus inputs are oversampled, and the FSM steps on detected 7 MHz edges.
// Commands queue in a DEPTH-entry FIFO. CMD_READY drops when the FIFO is full, and every command returns exactly one ordered response.
module pistorm_bus_engine #(
  parameter int ADDR_W      = 24,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int E_DIV       = 10,
  parameter int E_HIGH      = 4,
  parameter int VMA_START   = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                       PI_CLK,
  input  logic                       PI_RST,
  input  logic                       CMD_VALID,
  output logic                       CMD_READY,
  input  logic                       CMD_RW,
  input  logic                       CMD_SIZE,
  input  logic [2:0]                 CMD_FC,
  input  logic [ADDR_W-1:0]          CMD_ADDR,
  input  logic [15:0]                CMD_WDATA,
  output logic                       RSP_VALID,
  output logic [15:0]                RSP_RDATA,
  output logic                       RSP_BERR,
  output logic                       RSP_TMO,
  output logic                       RSP_AERR,
  output logic                       BUSY,
  output logic [$clog2(DEPTH+1)-1:0] FIFO_LEVEL,
  input  logic                       M68K_CLK,
  output logic [ADDR_W-2:0]          M68K_A,
  output logic [2:0]                 M68K_FC,
  input  logic [15:0]                M68K_D_IN,
  output logic [15:0]                M68K_D_OUT,
  output logic                       M68K_D_OE,
  output logic                       M68K_AS_n,
  output logic                       M68K_UDS_n,
  output logic                       M68K_LDS_n,
  output logic                       M68K_RW,
  input  logic                       M68K_DTACK_n,
  input  logic                       M68K_BERR_n,
  input  logic                       M68K_VPA_n,
  output logic                       M68K_E,
  output logic                       M68K_VMA_n
);

  localparam int LW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam int EW = $clog2(E_DIV);
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [EW-1:0] E_LAST     = EW'(E_DIV-1);
  localparam logic [EW-1:0] E_HI_START = EW'(E_DIV-E_HIGH);
  localparam logic [EW-1:0] E_END      = EW'(E_DIV-2);
  localparam logic [EW-1:0] E_VMA      = EW'(VMA_START);
  localparam logic [TW-1:0] TMO_LAST   = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC-1 : 0);
  localparam logic [LW-1:0] LVL_FULL   = LW'(DEPTH);

  typedef struct packed {
    logic              rw;
    logic              size;
    logic [2:0]        fc;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       wdata;
  } cmd_t;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_WAIT, S_SAMPLE, S_END} state_t;

  logic [SYNC_STAGES-1:0] r_clk_s, r_dtack_s, r_berr_s, r_vpa_s;
  logic                   r_c7_d;
  logic                   w_c7_rise, w_c7_fall, w_dtack_n, w_berr_n, w_vpa_n;

  always_ff @(posedge PI_CLK or posedge PI_RST) begin
    if (PI_RST) begin
      r_clk_s   <= '0;
      r_dtack_s <= '1;
      r_berr_s  <= '1;
      r_vpa_s   <= '1;
      r_c7_d    <= 1'b0;
    end else begin
      r_clk_s   <= {r_clk_s[SYNC_STAGES-2:0], M68K_CLK};
      r_dtack_s <= {r_dtack_s[SYNC_STAGES-2:0], M68K_DTACK_n};
      r_berr_s  <= {r_berr_s[SYNC_STAGES-2:0], M68K_BERR_n};
      r_vpa_s   <= {r_vpa_s[SYNC_STAGES-2:0], M68K_VPA_n};
      r_c7_d    <= r_clk_s[SYNC_STAGES-1];
    end
  end

  assign w_c7_rise = r_clk_s[SYNC_STAGES-1] & ~r_c7_d;
  assign w_c7_fall = ~r_clk_s[SYNC_STAGES-1] & r_c7_d;
  assign w_dtack_n = r_dtack_s[SYNC_STAGES-1];
  assign w_berr_n  = r_berr_s[SYNC_STAGES-1];
  assign w_vpa_n   = r_vpa_s[SYNC_STAGES-1];

  cmd_t          r_mem [DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [LW-1:0] r_level;
  logic          w_push, w_pop;
  cmd_t          w_head, w_cmd_in;
  state_t        r_state;

  assign CMD_READY = (r_level != LVL_FULL);
  assign w_push    = CMD_VALID && CMD_READY;
  assign w_pop     = (r_state == S_IDLE) && w_c7_fall && (r_level != '0);
  assign w_head    = r_mem[r_rptr];
  assign w_cmd_in  = '{rw: CMD_RW, size: CMD_SIZE, fc: CMD_FC, addr: CMD_ADDR, wdata: CMD_WDATA};

  always_ff @(posedge PI_CLK) begin
    if (w_push) r_mem[r_wptr] <= w_cmd_in;
  end

  always_ff @(posedge PI_CLK or posedge PI_RST) begin
    if (PI_RST) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  logic              r_op_rw, r_op_size, r_op_a0, r_berr, r_tmo;
  logic [15:0]       r_op_wdata;
  logic [EW-1:0]     r_e_cnt;
  logic [TW-1:0]     r_tcnt;
  logic [ADDR_W-2:0] r_a;
  logic [2:0]        r_fc;
  logic [15:0]       r_d_out, r_rsp_rdata;
  logic              r_d_oe, r_as_n, r_uds_n, r_lds_n, r_rw, r_vma_n, r_e;
  logic              r_rsp_valid, r_rsp_berr, r_rsp_tmo, r_rsp_aerr, r_busy;
  logic              w_uds_n, w_lds_n;

  // Byte cycles use one data lane: an even address selects UDS and an odd address selects LDS.
  assign w_uds_n = r_op_size ? 1'b0 : r_op_a0;
  assign w_lds_n = r_op_size ? 1'b0 : ~r_op_a0;

  always_ff @(posedge PI_CLK or posedge PI_RST) begin
    if (PI_RST) begin
      r_state     <= S_IDLE;
      r_op_rw     <= 1'b1;
      r_op_size   <= 1'b0;
      r_op_a0     <= 1'b0;
      r_op_wdata  <= '0;
      r_berr      <= 1'b0;
      r_tmo       <= 1'b0;
      r_e_cnt     <= '0;
      r_tcnt      <= '0;
      r_a         <= '0;
      r_fc        <= '0;
      r_d_out     <= '0;
      r_d_oe      <= 1'b0;
      r_as_n      <= 1'b1;
      r_uds_n     <= 1'b1;
      r_lds_n     <= 1'b1;
      r_rw        <= 1'b1;
      r_vma_n     <= 1'b1;
      r_e         <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_berr  <= 1'b0;
      r_rsp_tmo   <= 1'b0;
      r_rsp_aerr  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_busy      <= (r_level != '0) || (r_state != S_IDLE);
      r_e         <= (r_e_cnt >= E_HI_START);
      if (w_c7_fall) r_e_cnt <= (r_e_cnt == E_LAST) ? '0 : r_e_cnt + 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_op_rw    <= w_head.rw;
            r_op_size  <= w_head.size;
            r_op_a0    <= w_head.addr[0];
            r_op_wdata <= w_head.wdata;
            r_berr     <= 1'b0;
            r_tmo      <= 1'b0;
            if (w_head.size && w_head.addr[0]) begin
              r_rsp_valid <= 1'b1;
              r_rsp_aerr  <= 1'b1;
              r_rsp_berr  <= 1'b0;
              r_rsp_tmo   <= 1'b0;
            end else begin
              r_a     <= w_head.addr[ADDR_W-1:1];
              r_fc    <= w_head.fc;
              r_state <= S_ADDR;
            end
          end
        end
        S_ADDR: begin
          if (w_c7_rise) begin
            r_as_n <= 1'b0;
            r_rw   <= r_op_rw;
            if (r_op_rw) begin
              r_uds_n <= w_uds_n;
              r_lds_n <= w_lds_n;
            end
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_c7_fall) begin
            if (!r_op_rw) begin
              r_d_out <= r_op_wdata;
              r_d_oe  <= 1'b1;
            end
            r_tcnt  <= '0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_c7_rise && !r_op_rw) begin
            r_uds_n <= w_uds_n;
            r_lds_n <= w_lds_n;
          end
          if (w_c7_fall) begin
            if (r_tcnt != TMO_LAST) r_tcnt <= r_tcnt + 1'b1;
            // Termination sources are ranked: BERR, DTACK, end of the VPA/E cycle, VMA assertion, then timeout.
            if (!w_berr_n) begin
              r_berr  <= 1'b1;
              r_state <= S_SAMPLE;
            end else if (!w_dtack_n) begin
              r_state <= S_SAMPLE;
            end else if (!r_vma_n && (r_e_cnt == E_END)) begin
              r_state <= S_SAMPLE;
            end else if (!w_vpa_n && r_vma_n && (r_e_cnt == E_VMA)) begin
              r_vma_n <= 1'b0;
            end else if ((TIMEOUT_CYC != 0) && (r_tcnt == TMO_LAST)) begin
              r_tmo   <= 1'b1;
              r_state <= S_SAMPLE;
            end
          end
        end
        S_SAMPLE: begin
          if (w_c7_fall) begin
            if (r_op_rw) r_rsp_rdata <= M68K_D_IN;
            r_as_n  <= 1'b1;
            r_uds_n <= 1'b1;
            r_lds_n <= 1'b1;
            r_vma_n <= 1'b1;
            r_state <= S_END;
          end
        end
        S_END: begin
          if (w_c7_rise) begin
            r_rw        <= 1'b1;
            r_d_oe      <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_berr  <= r_berr;
            r_rsp_tmo   <= r_tmo;
            r_rsp_aerr  <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign RSP_VALID  = r_rsp_valid;
  assign RSP_RDATA  = r_rsp_rdata;
  assign RSP_BERR   = r_rsp_berr;
  assign RSP_TMO    = r_rsp_tmo;
  assign RSP_AERR   = r_rsp_aerr;
  assign BUSY       = r_busy;
  assign FIFO_LEVEL = r_level;
  assign M68K_A     = r_a;
  assign M68K_FC    = r_fc;
  assign M68K_D_OUT = r_d_out;
  assign M68K_D_OE  = r_d_oe;
  assign M68K_AS_n  = r_as_n;
  assign M68K_UDS_n = r_uds_n;
  assign M68K_LDS_n = r_lds_n;
  assign M68K_RW    = r_rw;
  assign M68K_E     = r_e;
  assign M68K_VMA_n = r_vma_n;

endmodule

// File: tb/tb_pistorm_bus_engine.sv
`timescale 1ns/1ps
// Directed bench for pistorm_bus_engine: PI_CLK runs at 100 MHz and M68K_CLK at 12.5 MHz, asynchronous to PI_CLK.
module tb_pistorm_bus_engine;

  logic        PI_CLK = 1'b0;
  logic        PI_RST = 1'b1;
  logic        CMD_VALID = 1'b0;
  logic        CMD_READY;
  logic        CMD_RW = 1'b0;
  logic        CMD_SIZE = 1'b0;
  logic [2:0]  CMD_FC = 3'd0;
  logic [23:0] CMD_ADDR = 24'd0;
  logic [15:0] CMD_WDATA = 16'd0;
  logic        RSP_VALID;
  logic [15:0] RSP_RDATA;
  logic        RSP_BERR, RSP_TMO, RSP_AERR, BUSY;
  logic [2:0]  FIFO_LEVEL;
  logic        M68K_CLK = 1'b0;
  logic [22:0] M68K_A;
  logic [2:0]  M68K_FC;
  logic [15:0] M68K_D_IN;
  logic [15:0] M68K_D_OUT;
  logic        M68K_D_OE, M68K_AS_n, M68K_UDS_n, M68K_LDS_n, M68K_RW;
  logic        M68K_DTACK_n = 1'b0;
  logic        M68K_BERR_n = 1'b1;
  logic        M68K_VPA_n = 1'b1;
  logic        M68K_E, M68K_VMA_n;
  logic        din_ovr = 1'b0;

  pistorm_bus_engine #(.ADDR_W(24), .DEPTH(4), .SYNC_STAGES(2), .E_DIV(10), .E_HIGH(4),
                       .VMA_START(2), .TIMEOUT_CYC(16)) dut (
    .PI_CLK(PI_CLK), .PI_RST(PI_RST),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_RW(CMD_RW), .CMD_SIZE(CMD_SIZE),
    .CMD_FC(CMD_FC), .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_BERR(RSP_BERR), .RSP_TMO(RSP_TMO),
    .RSP_AERR(RSP_AERR), .BUSY(BUSY), .FIFO_LEVEL(FIFO_LEVEL),
    .M68K_CLK(M68K_CLK), .M68K_A(M68K_A), .M68K_FC(M68K_FC), .M68K_D_IN(M68K_D_IN),
    .M68K_D_OUT(M68K_D_OUT), .M68K_D_OE(M68K_D_OE), .M68K_AS_n(M68K_AS_n),
    .M68K_UDS_n(M68K_UDS_n), .M68K_LDS_n(M68K_LDS_n), .M68K_RW(M68K_RW),
    .M68K_DTACK_n(M68K_DTACK_n), .M68K_BERR_n(M68K_BERR_n), .M68K_VPA_n(M68K_VPA_n),
    .M68K_E(M68K_E), .M68K_VMA_n(M68K_VMA_n)
  );

  // The bus slave returns data derived from the address, so each read has a predictable value.
  assign M68K_D_IN = din_ovr ? 16'hA5C3 : {M68K_A[7:0], ~M68K_A[7:0]};

  always #5 PI_CLK = ~PI_CLK;
  initial begin
    #3;
    forever #40 M68K_CLK = ~M68K_CLK;
  end

  int          n_assert = 0;
  int          n_fail = 0;
  int          rsp_cnt = 0;
  int          rd_idx = 0;
  int          as_low_cnt = 0;
  int          rw_low_cnt = 0;
  int          as_falls = 0;
  int          m_falls = 0;
  int          e_model = 0;
  logic [18:0] rsp_mem [64];

  always @(negedge PI_CLK) begin
    if (RSP_VALID) begin
      rsp_mem[rsp_cnt[5:0]] <= {RSP_AERR, RSP_TMO, RSP_BERR, RSP_RDATA};
      rsp_cnt <= rsp_cnt + 1;
    end
    if (!M68K_AS_n) as_low_cnt <= as_low_cnt + 1;
    if (!M68K_RW) rw_low_cnt <= rw_low_cnt + 1;
  end

  always @(negedge M68K_AS_n) as_falls <= as_falls + 1;
  always @(negedge M68K_CLK) m_falls <= m_falls + 1;
  always @(negedge M68K_CLK or posedge PI_RST) begin
    if (PI_RST) e_model <= 0;
    else e_model <= (e_model == 9) ? 0 : e_model + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] din_of(input logic [23:0] addr);
    din_of = {addr[8:1], ~addr[8:1]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic cond(input int which);
    case (which)
      0:       cond = (M68K_AS_n == 1'b0);
      1:       cond = (M68K_LDS_n == 1'b0);
      2:       cond = (M68K_VMA_n == 1'b0);
      default: cond = (FIFO_LEVEL == 3'd0);
    endcase
  endfunction

  task automatic wait_until(input int which, input string tag);
    int n = 0;
    @(negedge PI_CLK);
    while (!cond(which) && n < 20000) begin
      @(negedge PI_CLK);
      n++;
    end
    chk(tag, 32'(cond(which)), 32'd1);
  endtask

  task automatic push(input logic rw, input logic sz, input logic [2:0] fc,
                      input logic [23:0] addr, input logic [15:0] wd);
    int n = 0;
    @(negedge PI_CLK);
    CMD_VALID = 1'b1;
    CMD_RW    = rw;
    CMD_SIZE  = sz;
    CMD_FC    = fc;
    CMD_ADDR  = addr;
    CMD_WDATA = wd;
    while (!CMD_READY && n < 20000) begin
      @(negedge PI_CLK);
      n++;
    end
    chk("push_ready", 32'(CMD_READY), 32'd1);
    @(negedge PI_CLK);
    CMD_VALID = 1'b0;
  endtask

  task automatic wait_rsp(output logic [18:0] r);
    int n = 0;
    while (rsp_cnt <= rd_idx && n < 20000) begin
      @(negedge PI_CLK);
      n++;
    end
    chk("rsp_wait", 32'(rsp_cnt > rd_idx), 32'd1);
    if (rsp_cnt > rd_idx) begin
      r = rsp_mem[rd_idx[5:0]];
      rd_idx++;
    end else begin
      r = '1;
    end
  endtask

  initial begin
    logic [18:0] r;
    logic [23:0] addrs [6];
    int a0, w0, f0, c0;

    // Reset state
    #50;
    chk("rst_strobes", 32'({M68K_AS_n, M68K_UDS_n, M68K_LDS_n, M68K_RW, M68K_VMA_n}), 32'h1F);
    chk("rst_e_oe", 32'({M68K_E, M68K_D_OE}), 32'h0);
    chk("rst_rsp", 32'({RSP_VALID, RSP_BERR, RSP_TMO, RSP_AERR}), 32'h0);
    chk("rst_level", 32'(FIFO_LEVEL), 32'h0);
    chk("rst_ready_busy", 32'({CMD_READY, BUSY}), 32'h2);
    #50;
    PI_RST = 1'b0;

    // E clock: high for counts 6..9 of the 10-fall period
    for (int i = 0; i < 10; i++) begin
      @(posedge M68K_CLK);
      #20;
      chk("e_clock", 32'(M68K_E), 32'(e_model >= 6));
    end

    // Word read; DTACK is asserted on the second WAIT fall
    din_ovr = 1'b1;
    M68K_DTACK_n = 1'b1;
    a0 = as_low_cnt;
    w0 = rw_low_cnt;
    push(1'b1, 1'b1, 3'd5, 24'hBFE000, 16'h0000);
    wait_until(0, "t1_as_low");
    chk("t1_addr", 32'(M68K_A), 32'h5FF000);
    chk("t1_fc", 32'(M68K_FC), 32'd5);
    chk("t1_lanes", 32'({M68K_UDS_n, M68K_LDS_n}), 32'h0);
    @(negedge M68K_CLK);
    @(negedge M68K_CLK);
    @(posedge M68K_CLK);
    M68K_DTACK_n = 1'b0;
    wait_rsp(r);
    chk("t1_rsp", 32'(r), 32'h0000A5C3);
    chk("t1_as_width", 32'((as_low_cnt - a0) >= 16), 32'd1);
    chk("t1_rw_high", 32'(rw_low_cnt - w0), 32'd0);
    din_ovr = 1'b0;

    // Byte write to an odd address uses the lower lane only
    push(1'b0, 1'b0, 3'd1, 24'h000101, 16'h0012);
    wait_until(0, "t2_as_low");
    chk("t2_rw_at_as", 32'({M68K_RW, M68K_D_OE}), 32'h0);
    chk("t2_lanes_idle", 32'({M68K_UDS_n, M68K_LDS_n}), 32'h3);
    wait_until(1, "t2_lds_low");
    chk("t2_uds", 32'(M68K_UDS_n), 32'd1);
    chk("t2_doe", 32'(M68K_D_OE), 32'd1);
    chk("t2_dout", 32'(M68K_D_OUT), 32'h0012);
    chk("t2_rw", 32'(M68K_RW), 32'd0);
    chk("t2_addr", 32'(M68K_A), 32'h80);
    wait_rsp(r);
    chk("t2_flags", 32'(r[18:16]), 32'h0);
    chk("t2_end", 32'({M68K_RW, M68K_D_OE, M68K_AS_n}), 32'h5);

    // Fill the queue behind a stalled cycle, then release DTACK
    for (int i = 0; i < 6; i++) addrs[i] = 24'h000010 + 24'(i * 34);
    M68K_DTACK_n = 1'b1;
    push(1'b1, 1'b1, 3'd2, addrs[0], 16'h0);
    wait_until(3, "t3_popped");
    for (int i = 1; i < 5; i++) push(1'b1, 1'b1, 3'd2, addrs[i], 16'h0);
    chk("t3_ready_low", 32'(CMD_READY), 32'd0);
    chk("t3_level_full", 32'(FIFO_LEVEL), 32'd4);
    chk("t3_busy", 32'(BUSY), 32'd1);
    M68K_DTACK_n = 1'b0;
    push(1'b1, 1'b1, 3'd2, addrs[5], 16'h0);
    for (int i = 0; i < 6; i++) begin
      wait_rsp(r);
      chk("t3_order", 32'(r), 32'({3'b000, din_of(addrs[i])}));
    end
    repeat (4) @(negedge PI_CLK);
    chk("t3_idle", 32'({BUSY, FIFO_LEVEL}), 32'h0);

    // DTACK never arrives; the 16th WAIT fall times the cycle out
    M68K_DTACK_n = 1'b1;
    push(1'b1, 1'b1, 3'd5, 24'h000200, 16'h0);
    wait_until(0, "t4_as_low");
    f0 = m_falls;
    wait_rsp(r);
    chk("t4_falls", 32'(m_falls - f0), 32'd18);
    chk("t4_flags", 32'(r[18:16]), 32'h2);
    chk("t4_strobes", 32'({M68K_AS_n, M68K_UDS_n, M68K_LDS_n}), 32'h7);
    M68K_DTACK_n = 1'b0;
    push(1'b1, 1'b1, 3'd5, 24'h000204, 16'h0);
    wait_rsp(r);
    chk("t4_next", 32'(r), 32'({3'b000, din_of(24'h000204)}));

    // Bus error termination
    M68K_DTACK_n = 1'b1;
    M68K_BERR_n = 1'b0;
    push(1'b1, 1'b1, 3'd5, 24'h000300, 16'h0);
    wait_rsp(r);
    chk("berr_flags", 32'(r[18:16]), 32'h1);
    M68K_BERR_n = 1'b1;

    // VPA cycle: VMA asserts at e_cnt 2, and the cycle ends at e_cnt 8
    M68K_VPA_n = 1'b0;
    push(1'b1, 1'b1, 3'd5, 24'h000F00, 16'h0);
    wait_until(2, "t5_vma_low");
    chk("t5_vma_phase", 32'(e_model), 32'd3);
    chk("t5_as", 32'(M68K_AS_n), 32'd0);
    wait_rsp(r);
    chk("t5_rsp", 32'(r), 32'({3'b000, din_of(24'h000F00)}));
    chk("t5_end_phase", 32'(e_model), 32'd0);
    chk("t5_vma_high", 32'(M68K_VMA_n), 32'd1);
    M68K_VPA_n = 1'b1;

    // Reset pulse in WAIT with three commands queued
    push(1'b1, 1'b1, 3'd5, 24'h000400, 16'h0);
    wait_until(3, "t6_popped");
    push(1'b1, 1'b1, 3'd5, 24'h000402, 16'h0);
    push(1'b1, 1'b1, 3'd5, 24'h000404, 16'h0);
    push(1'b1, 1'b1, 3'd5, 24'h000406, 16'h0);
    chk("t6_level", 32'(FIFO_LEVEL), 32'd3);
    wait_until(0, "t6_as_low");
    @(negedge M68K_CLK);
    @(negedge M68K_CLK);
    #10;
    c0 = rsp_cnt;
    PI_RST = 1'b1;
    #1;
    chk("t6_strobes", 32'({M68K_AS_n, M68K_UDS_n, M68K_LDS_n, M68K_RW, M68K_VMA_n}), 32'h1F);
    chk("t6_oe_valid", 32'({M68K_D_OE, RSP_VALID}), 32'h0);
    chk("t6_level_zero", 32'(FIFO_LEVEL), 32'd0);
    #10;
    PI_RST = 1'b0;
    M68K_DTACK_n = 1'b0;
    repeat (200) @(negedge PI_CLK);
    chk("t6_no_rsp", 32'(rsp_cnt - c0), 32'd0);
    chk("t6_busy", 32'(BUSY), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge M68K_CLK);
      #20;
      chk("t6_e_realign", 32'(M68K_E), 32'(e_model >= 6));
    end

    // A word access at an odd address is rejected without a bus cycle
    f0 = as_falls;
    push(1'b1, 1'b1, 3'd5, 24'h000123, 16'h0);
    wait_rsp(r);
    chk("aerr_flags", 32'(r[18:16]), 32'h4);
    repeat (20) @(negedge PI_CLK);
    chk("aerr_no_as", 32'(as_falls - f0), 32'd0);
    chk("aerr_idle", 32'({M68K_AS_n, BUSY}), 32'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
